// File: rtl/pipelined_add_sub.sv
// Pipelined add/sub: carry chain cut into STAGES slices, one register per slice, flags from the output register.
// Latency STAGES cycles, 1 beat/cycle; when out_valid & ~out_ready the whole pipe holds, bubbles included.
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] add_result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SW = WIDTH / STAGES;

  generate
    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
      $error("pipelined_add_sub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end
  endgenerate

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
  } stage_t;

  stage_t      src      [STAGES];
  stage_t      nxt      [STAGES];
  stage_t      pipe_q   [STAGES];
  logic [SW:0] slice_sum[STAGES];
  logic        ovf_nxt;
  logic        ovf_q;
  logic        adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Subtraction is folded in at the head: B and the borrow are inverted once, so every slice is a plain adder.
  always_comb begin
    src[0] = '{vld: in_valid, a: input_a, b: input_b ^ {WIDTH{sub}}, s: '0, c: cin ^ sub};
    for (int k = 1; k < STAGES; k++) begin
      src[k] = pipe_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice_sum[k] = {1'b0, src[k].a[k*SW +: SW]} + {1'b0, src[k].b[k*SW +: SW]}
                   + {{SW{1'b0}}, src[k].c};
      nxt[k]                 = src[k];
      nxt[k].s[k*SW +: SW]   = slice_sum[k][SW-1:0];
      nxt[k].c               = slice_sum[k][SW];
    end
    // Carry into the MSB is recovered from the MSB operand and sum bits.
    ovf_nxt = src[STAGES-1].a[WIDTH-1] ^ src[STAGES-1].b[WIDTH-1]
            ^ nxt[STAGES-1].s[WIDTH-1] ^ nxt[STAGES-1].c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        pipe_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        pipe_q[k] <= nxt[k];
      end
      ovf_q <= ovf_nxt;
    end
  end

  assign out_valid  = pipe_q[STAGES-1].vld;
  assign add_result = pipe_q[STAGES-1].s;
  assign cout       = pipe_q[STAGES-1].c;
  assign overflow   = ovf_q;
  assign zero       = (add_result == '0);
  assign negative   = add_result[WIDTH-1];

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined successor to the team's 32-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands with carry/borrow-in.
- The carry chain is split into STAGES equal slices, with one register boundary per slice, to close timing at wider widths.
- Valid/ready handshakes on both sides; produces carry, signed-overflow, zero and negative flags for the ALU datapath of the single-cycle/multi-cycle MIPS core.

Parameters:
- WIDTH, 32, operand/result width in bits; WIDTH % STAGES == 0 required.
- STAGES, 4, pipeline depth and carry-chain slice count; 1 <= STAGES <= WIDTH; slice width SW = WIDTH/STAGES.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  pipeline can accept a beat this cycle.
- input_a  input  WIDTH  operand A.
- input_b  input  WIDTH  operand B.
- cin  input  1  carry-in (sub=0) or borrow-in (sub=1).
- sub  input  1  0: A+B+cin; 1: A-B-cin.
- out_valid  output  1  result beat available.
- out_ready  input  1  downstream accepts result.
- add_result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  add_result == 0.
- negative  output  1  add_result[WIDTH-1].

Behaviour:
- Effective operation: A + (sub ? ~B : B) + (sub ? ~cin : cin), computed as a WIDTH-bit sum plus carry.
- Stage k (k = 0..STAGES-1):
  - Adds bits [k*SW +: SW] using the carry registered from stage k-1 (stage 0 uses the effective cin).
  - Result bits below the slice and operand bits above it travel in pipeline registers alongside.
- overflow = carry into MSB XOR carry out of MSB, computed in the last stage.
- zero and negative are computed combinationally from the final registered result.
- Global advance enable: adv = ~out_valid | out_ready. in_ready = adv.
- On adv, all stage registers shift one stage and a valid bit shifts with them; stage 0 loads when in_valid & in_ready.
- On ~adv, every stage register holds, including bubbles; bubbles are not compressed while stalled.
- Latency: a beat accepted at edge N is presented with out_valid=1 after edge N+STAGES-1 (STAGES cycles of registering, including the output register), provided no stall. Throughput is 1 beat/cycle.
- Output hold: while out_valid & ~out_ready, add_result and all flags are stable.
- Ordering: results leave in acceptance order. No beat is lost or duplicated under any in_valid/out_ready pattern.
- Simultaneous accept and drain in the same cycle is legal and sustains full throughput.
- Reset (reset_n low, any time, including mid-operation):
  - Clears immediately: all valid bits, out_valid, add_result, cout, overflow.
  - Consequently zero=1 and negative=0 during reset; in_ready=1.
  - In-flight beats are discarded; no stale beat appears after release.
- Inputs are sampled only on accepting edges; values while in_valid=0 are don't-care.
- STAGES=1: a single registered adder with latency 1 and the same handshake.
- Elaboration must fail if WIDTH % STAGES != 0.

Test Plan (WIDTH=32, STAGES=4 unless noted):
1. Wrap: 0xFFFFFFFF + 0x00000001, cin=0, sub=0, out_ready=1 → 4 cycles later add_result=0x00000000, cout=1, zero=1, overflow=0, negative=0.
2. Signed overflow: 0x7FFFFFFF + 0x00000001 → 0x80000000, overflow=1, negative=1, cout=0. Also 0x80000000 - 0x00000001, sub=1 → 0x7FFFFFFF, overflow=1, cout=1.
3. Subtract/borrow:
   - 5 - 7, cin=0 → 0xFFFFFFFE, cout=0, negative=1.
   - 7 - 5 → 0x00000002, cout=1.
   - 7 - 5, cin=1 → 0x00000001.
4. Slice carry ripple: 0x00FFFFFF + 0x00000001 with cin=1 → 0x01000001, which exercises carry across three slice boundaries.
5. Backpressure:
   - Stream 8 beats back-to-back with random out_ready.
   - Expect in_ready to track ~out_valid | out_ready and results to arrive in order, with none dropped or repeated.
   - Expect outputs to stay stable while stalled.
   - Full rate is sustained when out_ready=1.
6. Reset mid-flight: 3 beats in flight, pulse reset_n low asynchronously between edges → out_valid=0 and add_result=0 immediately; after release, no stale out_valid. Repeat case 1 with STAGES=1 → latency 1.
